// File: rtl/tank_bullet.sv
// Tank bullet engine: fires one bullet on a fire-key press, moves it every
// frame along the tank's heading, reflects it off the playfield walls and
// retires it on a hit or when its lifetime runs out, followed by a cooldown.
module tank_bullet #(
  parameter logic [5:0] SPEED    = 6'd4,
  parameter logic [7:0] LIFETIME = 8'd255,
  parameter logic [3:0] COOLDOWN = 4'd15,
  parameter logic [7:0] FIRE_KEY = 8'h10,
  parameter int         X_MIN    = 0,
  parameter int         X_MAX    = 639,
  parameter int         Y_MIN    = 0,
  parameter int         Y_MAX    = 479
) (
  input  logic        frame_clk,
  input  logic        Reset,
  input  logic [31:0] keycode,
  input  logic [9:0]  TankX,
  input  logic [9:0]  TankY,
  input  logic [7:0]  sin,
  input  logic [7:0]  cos,
  input  logic        Hit,
  output logic [9:0]  BulletX,
  output logic [9:0]  BulletY,
  output logic [9:0]  BulletS,
  output logic        Active,
  output logic [2:0]  Bounces
);

  typedef enum logic [1:0] {IDLE, FLY, COOL} state_t;

  // Playfield bounds in the same signed width as the next-position sums.
  localparam logic signed [10:0] X_LO = 11'(X_MIN);
  localparam logic signed [10:0] X_HI = 11'(X_MAX);
  localparam logic signed [10:0] Y_LO = 11'(Y_MIN);
  localparam logic signed [10:0] Y_HI = 11'(Y_MAX);

  state_t             state;
  logic        [7:0]  vel_x;
  logic        [7:0]  vel_y;
  logic        [7:0]  life;
  logic        [3:0]  cool_cnt;
  logic               key_held;
  logic               key_now;
  logic               fire_edge;
  logic signed [10:0] next_x;
  logic signed [10:0] next_y;
  logic               x_out;
  logic               y_out;

  // Scale a sign-magnitude sin/cos sample to a two's complement velocity.
  function automatic logic [7:0] scale_vel(input logic [7:0] sm);
    logic [12:0] prod;
    logic [7:0]  mag;
    prod = 13'(sm[6:0]) * 13'(SPEED);
    mag  = {2'b00, prod[12:7]};
    return sm[7] ? (8'd0 - mag) : mag;
  endfunction

  assign BulletS = 10'd4;

  assign key_now = (keycode[7:0]   == FIRE_KEY) || (keycode[15:8]  == FIRE_KEY) ||
                   (keycode[23:16] == FIRE_KEY) || (keycode[31:24] == FIRE_KEY);
  assign fire_edge = key_now && !key_held;

  // Candidate positions one step ahead; sign extension lets a step past zero
  // show up as a negative value rather than wrapping to a large coordinate.
  assign next_x = $signed({1'b0, BulletX}) + $signed({{3{vel_x[7]}}, vel_x});
  assign next_y = $signed({1'b0, BulletY}) + $signed({{3{vel_y[7]}}, vel_y});
  assign x_out  = (next_x < X_LO) || (next_x > X_HI);
  assign y_out  = (next_y < Y_LO) || (next_y > Y_HI);

  // Shot lifecycle: idle -> flying -> cooling down -> idle, with all outputs
  // registered. The key history is forced to "held" during reset so a key
  // already down when reset lifts must be released before it can fire.
  always_ff @(posedge frame_clk) begin
    if (!Reset) begin
      state    <= IDLE;
      BulletX  <= 10'd0;
      BulletY  <= 10'd0;
      vel_x    <= 8'd0;
      vel_y    <= 8'd0;
      life     <= 8'd0;
      cool_cnt <= 4'd0;
      Bounces  <= 3'd0;
      Active   <= 1'b0;
      key_held <= 1'b1;
    end else begin
      key_held <= key_now;
      case (state)
        IDLE: begin
          if (fire_edge) begin
            BulletX <= TankX;
            BulletY <= TankY;
            vel_x   <= scale_vel(cos);
            vel_y   <= scale_vel(sin);
            life    <= LIFETIME;
            Bounces <= 3'd0;
            Active  <= 1'b1;
            state   <= FLY;
          end
        end
        FLY: begin
          if (Hit || life == 8'd0) begin
            cool_cnt <= COOLDOWN;
            Active   <= 1'b0;
            state    <= COOL;
          end else begin
            if (x_out) vel_x <= 8'd0 - vel_x;
            else       BulletX <= next_x[9:0];
            if (y_out) vel_y <= 8'd0 - vel_y;
            else       BulletY <= next_y[9:0];
            if ((x_out || y_out) && Bounces != 3'd7) Bounces <= Bounces + 3'd1;
            life <= life - 8'd1;
          end
        end
        COOL: begin
          if (cool_cnt == 4'd0) state <= IDLE;
          else                  cool_cnt <= cool_cnt - 4'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
